gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Parametrised direction predictor for the pipelined RISC-V core; generalises the single 2-bit saturating counter to a table of N-bit counters.
- Table is indexed by PC, optionally XORed with a global history register (GHR).
- Provides a combinational prediction to the IF stage.
- Takes resolved-branch updates from the EX stage, including GHR repair on misprediction.

Parameters:
- CTR_BITS, 2, width of each saturating counter (>=1).
- INDEX_BITS, 6, log2 of table entries (64 entries).
- HIST_BITS, 6, GHR width; must satisfy 1 <= HIST_BITS <= INDEX_BITS.
- MODE, 1, 0 = bimodal (index from PC only), 1 = gshare (PC XOR GHR).

Ports:
- clk  input  1  Rising-edge clock.
- reset  input  1  Asynchronous, active-low reset (asserted when 0).
- pred_valid  input  1  IF stage is fetching a control instruction this cycle.
- pred_pc  input  32  PC of the fetched instruction.
- pred_taken  output  1  Predicted direction (MSB of the indexed counter).
- pred_ghr  output  HIST_BITS  GHR snapshot used for this prediction; carried down the pipe.
- update_valid  input  1  EX stage resolved a control instruction this cycle.
- update_pc  input  32  PC of the resolved instruction.
- update_ghr  input  HIST_BITS  pred_ghr value that travelled with the resolved instruction.
- update_taken  input  1  Actual direction.
- update_mispredict  input  1  Actual direction differed from the prediction; valid only with update_valid.

Behaviour:
- Index function:
  - idx(pc, h) = pc[INDEX_BITS+1:2] XOR zero-extended h when MODE=1.
  - idx(pc, h) = pc[INDEX_BITS+1:2] when MODE=0.
  - PC bits [1:0] are ignored.
- Prediction (combinational, zero latency):
  - pred_taken = table[idx(pred_pc, ghr)][CTR_BITS-1].
  - pred_ghr = ghr.
  - Both outputs are valid regardless of pred_valid.
- Counter update (registered, one cycle). On a clock edge with update_valid=1, entry e = idx(update_pc, update_ghr) changes as follows:
  - update_taken=1: e increments, saturating at 2^CTR_BITS-1.
  - update_taken=0: e decrements, saturating at 0.
  - No wrap-around under any circumstances.
- GHR next-state, in priority order:
  1. update_valid & update_mispredict: ghr <= {update_ghr[HIST_BITS-2:0], update_taken}. This is the repair and overrides any same-cycle prediction. When HIST_BITS=1, ghr <= update_taken.
  2. Otherwise, pred_valid: ghr <= {ghr[HIST_BITS-2:0], pred_taken}. This is the speculative shift.
  3. Otherwise: hold.
- Correctly predicted updates never modify the GHR.
- Simultaneous predict and update to the same entry:
  - The prediction uses the pre-update value; there is no bypass.
  - The new value is visible from the next cycle.
- update_mispredict with update_valid=0 is ignored.
- Reset (reset=0, asynchronous):
  - Every counter = 2^(CTR_BITS-1)-1, i.e. weakly not-taken (01 for CTR_BITS=2).
  - ghr = 0.
  - pred_taken therefore reads 0 immediately after reset.
- Reset asserted mid-operation:
  - State clears without waiting for clk.
  - An update presented in the same cycle is discarded.
  - The first edge after deassertion is a normal operating edge.
- Table storage: flops (no SRAM), sized 2^INDEX_BITS x CTR_BITS.

Test Plan:
- Reset mid-run: drive reset=0 between clock edges after several updates -> all entries read 01 and ghr=0 immediately; pred_taken=0 for any pred_pc.
- Saturate high, MODE=0, pc=0x40: 4 taken updates -> counter sequence 01->10->11->11->11; pred_taken=1 from the cycle after the first update.
- Saturate low, pc=0x40: from reset, 2 not-taken updates -> counter 01->00->00; then one taken update -> 01, pred_taken still 0.
- GHR speculation and repair, MODE=1:
  - 3 pred_valid cycles, all predicting 0 -> ghr=000000.
  - Then update_valid, mispredict, update_taken=1, update_ghr=000001 in the same cycle as pred_valid -> ghr=000011 (repair wins over the speculative shift).
- gshare de-aliasing, MODE=1: pc=0x40 trained taken with ghr=000000; same pc with ghr=000001 -> indexes entries 0x10 and 0x11 respectively, and the second still predicts 0.
- Same-entry predict+update: counter=01, update taken and pred_pc on the same index in one cycle -> pred_taken=0 that cycle, 1 the next cycle.

Source files
------------

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// gshare_predictor : table of N-bit saturating direction counters, indexed by
//                    PC (optionally XOR global history); zero-latency predict,
//                    registered update with GHR repair on misprediction.
// Revision: 1.0
// ============================================================================
module gshare_predictor #(
  parameter int CTR_BITS   = 2,
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6,
  parameter int MODE       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_valid,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 update_valid,
  input  logic [31:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_ghr,
  input  logic                 update_taken,
  input  logic                 update_mispredict
);

  localparam int                  ENTRIES      = 1 << INDEX_BITS;
  localparam int                  CTR_INIT_INT = (1 << (CTR_BITS - 1)) - 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT     = CTR_INIT_INT[CTR_BITS-1:0];
  localparam logic [CTR_BITS-1:0] CTR_MAX      = '1;

  logic [CTR_BITS-1:0]   table_q [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_q;
  logic [HIST_BITS-1:0]  ghr_d;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic [CTR_BITS-1:0]   upd_ctr_d;
  logic [HIST_BITS-1:0]  ghr_repair;
  logic [HIST_BITS-1:0]  ghr_spec;

  if (MODE == 1) begin : g_mode_gshare
    assign pred_idx = pred_pc[INDEX_BITS+1:2]   ^ INDEX_BITS'(ghr_q);
    assign upd_idx  = update_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(update_ghr);
  end else begin : g_mode_bimodal
    assign pred_idx = pred_pc[INDEX_BITS+1:2];
    assign upd_idx  = update_pc[INDEX_BITS+1:2];
  end

  // Prediction reads the registered table only: a same-cycle update to the
  // same entry is seen one cycle later.
  assign pred_taken = table_q[pred_idx][CTR_BITS-1];
  assign pred_ghr   = ghr_q;
  assign upd_ctr    = table_q[upd_idx];

  always_comb begin
    upd_ctr_d = upd_ctr;
    if (update_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_d = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) upd_ctr_d = upd_ctr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_INIT;
    end else if (update_valid) begin
      table_q[upd_idx] <= upd_ctr_d;
    end
  end

  if (HIST_BITS == 1) begin : g_hist_one
    assign ghr_repair = update_taken;
    assign ghr_spec   = pred_taken;
  end else begin : g_hist_multi
    assign ghr_repair = {update_ghr[HIST_BITS-2:0], update_taken};
    assign ghr_spec   = {ghr_q[HIST_BITS-2:0], pred_taken};
  end

  // Repair from EX reflects architectural history and overrides the
  // speculative shift from IF.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid && update_mispredict) begin
      ghr_d = ghr_repair;
    end else if (pred_valid) begin
      ghr_d = ghr_spec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                       update_pc[31:INDEX_BITS+2], update_pc[1:0], update_ghr};

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
// tb_gshare_predictor : directed checks of bimodal (MODE=0) and gshare
//                       (MODE=1) instances driven with shared stimulus.
// Revision: 1.0
// ============================================================================
module tb_gshare_predictor;

  logic        clk;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [5:0]  update_ghr;
  logic        update_taken;
  logic        update_mispredict;

  logic        b_taken;
  logic [5:0]  b_ghr;
  logic        g_taken;
  logic [5:0]  g_ghr;

  int n_total = 0;
  int n_pass  = 0;

  gshare_predictor #(.CTR_BITS(2), .INDEX_BITS(6), .HIST_BITS(6), .MODE(0)) u_bim (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (b_taken),
    .pred_ghr         (b_ghr),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_ghr       (update_ghr),
    .update_taken     (update_taken),
    .update_mispredict(update_mispredict)
  );

  gshare_predictor #(.CTR_BITS(2), .INDEX_BITS(6), .HIST_BITS(6), .MODE(1)) u_gsh (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (g_taken),
    .pred_ghr         (g_ghr),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_ghr       (update_ghr),
    .update_taken     (update_taken),
    .update_mispredict(update_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One update across one clock edge; outputs settle before returning.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic mis, input logic [5:0] h);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_taken      = tk;
    update_mispredict = mis;
    update_ghr        = h;
    tick();
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b0; pred_valid = 1'b0; pred_pc = 32'h40;
    update_valid = 1'b0; update_pc = '0; update_ghr = '0;
    update_taken = 1'b0; update_mispredict = 1'b0;

    #2;
    check("rst_pred_bim", b_taken, 0);
    check("rst_pred_gsh", g_taken, 0);
    check("rst_ghr_gsh",  g_ghr,   0);
    check("rst_ghr_bim",  b_ghr,   0);
    #10 reset = 1'b1;

    // Saturate high at pc 0x40: 01->10->11->11->11, then two decrements 11->10->01
    for (int k = 0; k < 4; k++) begin
      upd(32'h40, 1'b1, 1'b0, 6'd0);
      check($sformatf("sat_hi_%0d", k), b_taken, 1);
    end
    upd(32'h40, 1'b0, 1'b0, 6'd0); check("sat_hi_dec1", b_taken, 1);
    upd(32'h40, 1'b0, 1'b0, 6'd0); check("sat_hi_dec2", b_taken, 0);

    // Saturate low: 01->00->00, then 01 (still 0), then 10
    upd(32'h40, 1'b0, 1'b0, 6'd0); check("sat_lo_dec1", b_taken, 0);
    upd(32'h40, 1'b0, 1'b0, 6'd0); check("sat_lo_dec2", b_taken, 0);
    upd(32'h40, 1'b1, 1'b0, 6'd0); check("sat_lo_inc1", b_taken, 0);
    upd(32'h40, 1'b1, 1'b0, 6'd0); check("sat_lo_inc2", b_taken, 1);

    // Build up state, then reset between edges
    upd(32'h80, 1'b1, 1'b0, 6'd0);
    upd(32'h80, 1'b1, 1'b0, 6'd0);
    upd(32'hFC, 1'b1, 1'b1, 6'b000001);
    pred_pc = 32'h80; #1;
    check("pre_rst_bim_80", b_taken, 1);
    check("pre_rst_ghr",    g_ghr,   6'b000011);

    reset = 1'b0;
    update_valid = 1'b1; update_pc = 32'h80; update_taken = 1'b1; update_ghr = 6'd0;
    #1;
    check("rst_async_ghr",    g_ghr,   0);
    check("rst_async_bim_80", b_taken, 0);
    pred_pc = 32'h40; #1;
    check("rst_async_bim_40", b_taken, 0);
    tick();
    #2;
    reset = 1'b1; update_valid = 1'b0;
    pred_pc = 32'h80; #1;
    check("rst_upd_discard", b_taken, 0);
    pred_pc = 32'h40;
    upd(32'h40, 1'b1, 1'b0, 6'd0);
    check("post_rst_edge_bim", b_taken, 1);
    check("post_rst_edge_gsh", g_taken, 1);

    // GHR speculation then repair in the same cycle as a prediction
    pred_pc = 32'h100; pred_valid = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("ghr_spec_zero", g_ghr, 0);
    update_valid = 1'b1; update_mispredict = 1'b1; update_taken = 1'b1;
    update_ghr = 6'b000001; update_pc = 32'h200;
    tick();
    update_valid = 1'b0; update_mispredict = 1'b0; pred_valid = 1'b0; #1;
    check("ghr_repair_wins", g_ghr, 6'b000011);
    pred_valid = 1'b1; #1;
    check("ghr_spec_pred", g_taken, 0);
    tick();
    pred_valid = 1'b0; #1;
    check("ghr_spec_shift", g_ghr, 6'b000110);
    upd(32'h300, 1'b1, 1'b0, 6'b000110);
    check("ghr_correct_hold", g_ghr, 6'b000110);
    update_mispredict = 1'b1; update_taken = 1'b1; update_ghr = 6'd0;
    tick();
    update_mispredict = 1'b0; #1;
    check("ghr_mis_no_valid", g_ghr, 6'b000110);

    // De-aliasing: pc 0x40 with ghr 0 hits entry 0x10 (trained), ghr 1 hits 0x11
    upd(32'hFC, 1'b0, 1'b1, 6'd0);
    pred_pc = 32'h40; #1;
    check("dealias_ghr0",  g_ghr,   0);
    check("dealias_pred0", g_taken, 1);
    upd(32'hFC, 1'b1, 1'b1, 6'd0);
    check("dealias_ghr1",  g_ghr,   6'b000001);
    check("dealias_pred1", g_taken, 0);
    check("dealias_bim",   b_taken, 1);

    // Same-entry predict and update: no bypass
    pred_pc = 32'h80;
    update_valid = 1'b1; update_pc = 32'h80; update_taken = 1'b1; update_ghr = 6'd0;
    #1;
    check("same_entry_pre", b_taken, 0);
    tick();
    update_valid = 1'b0; #1;
    check("same_entry_post", b_taken, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
